layer_priority_ctrl: RTL and testbench
======================================

Name: layer_priority_ctrl

Overview:
- Programmable, registered priority compositor and scheduler for the VGA drawing-request/RGB layer mux.
- Arbitrates NUM_LAYERS object layers (player, bombs, walls, HUD, ...) per pixel using a software-configurable priority order, per-layer enable and per-layer blink.
- Configuration is buffered and committed only at frame start, so the picture never tears.
- Sits between the per-object drawing blocks and the final VGA back-ground mux.

Parameters:
- NUM_LAYERS, 4, number of requesting layers (2..4; layer index width is 2 bits).
- BLINK_FRAMES, 16, blink half-period in frames (>=1).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-clk pulse at the first pixel of each frame
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_priority  in  2*NUM_LAYERS  slot s = bits[2s+1:2s] = layer index; slot 0 is highest priority
- cfg_enable  in  NUM_LAYERS  per-layer enable
- cfg_blink  in  NUM_LAYERS  per-layer blink enable
- DR_in  in  NUM_LAYERS  per-layer drawing request
- RGB_in  in  8*NUM_LAYERS  per-layer colour; layer i = bits[8i+7:8i]
- drawingRequest  out  1  some layer wins this pixel
- RGBout  out  8  winning colour, 8'h00 when no winner
- layer_id  out  2  index of winning layer, 0 when no winner
- collision  out  1  two or more eligible layers requested the same pixel
- blink_phase  out  1  current blink phase; 1 = blinking layers hidden

Behaviour:
- Reset (while reset=1 at posedge): drawingRequest=0, RGBout=8'h00, layer_id=0, collision=0, blink_phase=0, cfg_ready=0. Active priority = identity (slot s = layer s), active enable = all 1s, active blink = all 0s, shadow cleared, frame counter=0, FSM=IDLE. cfg_ready rises in the first cycle after reset deasserts.
- Eligible(i) = DR_in[i] & enable[i] & ~(blink[i] & blink_phase).
- Winner: scan slots 0..NUM_LAYERS-1. The first slot whose layer index is eligible wins. A layer listed in several slots is effectively placed at its highest slot. Slot values >= NUM_LAYERS are ignored.
- Pipeline: one register stage. Outputs at edge n+1 reflect DR_in/RGB_in and the active config sampled at edge n. Latency = 1 clk, throughput = 1 pixel per clk.
- collision = popcount(eligible) >= 2, registered with the other outputs.
- Config FSM:
  - IDLE: cfg_ready=1. On cfg_valid, capture cfg_* into the shadow and go to PENDING. Exception: if startOfFrame is high in the same cycle, copy cfg_* straight to the active registers and stay in IDLE.
  - PENDING: cfg_ready=0. On startOfFrame, copy shadow to active and go to IDLE. cfg_valid is ignored while in PENDING.
  - A commit takes effect for pixels sampled on the cycle after the startOfFrame edge.
- Blink: the frame counter increments on each startOfFrame. When it reaches BLINK_FRAMES-1 and startOfFrame arrives, it wraps to 0 and blink_phase toggles. blink_phase therefore changes only at frame start. Counter width = clog2(BLINK_FRAMES), minimum 1 bit.
- Simultaneous events:
  - startOfFrame + commit + blink toggle in the same cycle: all take effect together at that edge.
  - A pixel sampled in that same cycle uses the old config and old phase.
- Reset mid-operation (including in PENDING) discards the shadow and returns everything to reset values at that edge.
- No combinational path from any input to any output. cfg_ready is driven from FSM state only.

Test Plan:
- Identity priority, all enabled, DR_in=4'b0110, RGB layer1=8'hE0, layer2=8'h1C -> one clk later drawingRequest=1, RGBout=8'hE0, layer_id=1, collision=1. DR_in=0 -> RGBout=8'h00, drawingRequest=0, layer_id=0, collision=0.
- Offer cfg_priority={L0,L1,L3,L2} (slot0=2, slot1=3, slot2=1, slot3=0), cfg_valid in mid-frame -> cfg_ready drops next cycle and outputs keep identity order. After the next startOfFrame, DR_in=4'b0110 yields layer_id=2, RGBout=8'h1C, and cfg_ready returns to 1.
- cfg_valid asserted in the same cycle as startOfFrame -> new config active on the next pixel and cfg_ready stays 1 throughout. cfg_valid pulsed while in PENDING -> ignored, and the first shadow is the one committed.
- BLINK_FRAMES=2, blink[1]=1, DR_in=4'b0010 -> pixels drawn for 2 frames, hidden (drawingRequest=0) for 2 frames, repeating. blink_phase toggles only on startOfFrame edges.
- cfg_enable=4'b1101, DR_in=4'b0011 -> layer 0 wins with collision=0 (layer 1 is not eligible). Priority slots {0,0,0,0}: DR_in=4'b0010 -> drawingRequest=0.
- Assert reset while in PENDING -> the next startOfFrame keeps the identity config, and all outputs read 0 during reset.

Source files
------------

// File: rtl/layer_priority_ctrl.sv
// Layer priority compositor: per-pixel arbitration of drawing layers
// with frame-synchronous configuration commit and frame-based blink.
module layer_priority_ctrl #(
  parameter int NUM_LAYERS   = 4,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      startOfFrame,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [2*NUM_LAYERS-1:0]   cfg_priority,
  input  logic [NUM_LAYERS-1:0]     cfg_enable,
  input  logic [NUM_LAYERS-1:0]     cfg_blink,
  input  logic [NUM_LAYERS-1:0]     DR_in,
  input  logic [8*NUM_LAYERS-1:0]   RGB_in,
  output logic                      drawingRequest,
  output logic [7:0]                RGBout,
  output logic [1:0]                layer_id,
  output logic                      collision,
  output logic                      blink_phase
);

  localparam int N  = NUM_LAYERS;
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // INIT holds cfg_ready low for the reset cycle and releases it one clk later
  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_PEND
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2*N-1:0] act_prio;
  logic [N-1:0]   act_en;
  logic [N-1:0]   act_blink;
  logic [2*N-1:0] sh_prio;
  logic [N-1:0]   sh_en;
  logic [N-1:0]   sh_blink;
  logic [CW-1:0]  frame_cnt;

  logic           capture;
  logic           commit_direct;
  logic           commit_shadow;

  logic [N-1:0]   elig;
  logic           hit;
  logic [1:0]     wid;
  logic [7:0]     wrgb;
  logic [2:0]     req_cnt;

  function automatic logic [2*N-1:0] ident_prio();
    logic [2*N-1:0] p;
    p = '0;
    for (int s = 0; s < N; s++) begin
      p[2*s +: 2] = 2'(s);
    end
    return p;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state: a config offered on the frame-start cycle bypasses PENDING
  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT: state_nx = S_IDLE;
      S_IDLE: if (cfg_valid && !startOfFrame) state_nx = S_PEND;
      S_PEND: if (startOfFrame) state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  // FSM outputs: handshake and commit strobes
  always_comb begin
    cfg_ready     = (state == S_IDLE);
    capture       = (state == S_IDLE) && cfg_valid && !startOfFrame;
    commit_direct = (state == S_IDLE) && cfg_valid && startOfFrame;
    commit_shadow = (state == S_PEND) && startOfFrame;
  end

  // Shadow and active configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      act_prio  <= ident_prio();
      act_en    <= '1;
      act_blink <= '0;
      sh_prio   <= '0;
      sh_en     <= '0;
      sh_blink  <= '0;
    end else begin
      if (capture) begin
        sh_prio  <= cfg_priority;
        sh_en    <= cfg_enable;
        sh_blink <= cfg_blink;
      end
      if (commit_direct) begin
        act_prio  <= cfg_priority;
        act_en    <= cfg_enable;
        act_blink <= cfg_blink;
      end else if (commit_shadow) begin
        act_prio  <= sh_prio;
        act_en    <= sh_en;
        act_blink <= sh_blink;
      end
    end
  end

  // Frame counter and blink phase, advanced only at frame start
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (startOfFrame) begin
      if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Eligibility, collision count and slot scan; lowest slot wins
  always_comb begin
    elig    = DR_in & act_en & ~(act_blink & {N{blink_phase}});
    req_cnt = '0;
    hit     = 1'b0;
    wid     = '0;
    wrgb    = '0;
    for (int i = 0; i < N; i++) begin
      req_cnt = req_cnt + 3'(elig[i]);
    end
    for (int s = N - 1; s >= 0; s--) begin
      for (int i = 0; i < N; i++) begin
        if (act_prio[2*s +: 2] == 2'(i) && elig[i]) begin
          hit  = 1'b1;
          wid  = 2'(i);
          wrgb = RGB_in[8*i +: 8];
        end
      end
    end
  end

  // Registered pixel outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
      layer_id       <= 2'd0;
      collision      <= 1'b0;
    end else begin
      drawingRequest <= hit;
      RGBout         <= wrgb;
      layer_id       <= wid;
      collision      <= (req_cnt >= 3'd2);
    end
  end

endmodule

// File: tb/tb_layer_priority_ctrl.sv
// Directed bench for layer_priority_ctrl: vector table plus
// sequences for commit timing, reset in PENDING and blink.
module tb_layer_priority_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_priority;
  logic [3:0]  cfg_enable;
  logic [3:0]  cfg_blink;
  logic [3:0]  DR_in;
  logic [31:0] RGB_in;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic [1:0]  layer_id;
  logic        collision;
  logic        blink_phase;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  layer_priority_ctrl #(
    .NUM_LAYERS  (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_priority  (cfg_priority),
    .cfg_enable    (cfg_enable),
    .cfg_blink     (cfg_blink),
    .DR_in         (DR_in),
    .RGB_in        (RGB_in),
    .drawingRequest(drawingRequest),
    .RGBout        (RGBout),
    .layer_id      (layer_id),
    .collision     (collision),
    .blink_phase   (blink_phase)
  );

  typedef struct {
    logic [3:0] dr;
    logic       e_dr;
    logic [7:0] e_rgb;
    logic [1:0] e_id;
    logic       e_col;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_pix(input string name, input logic e_dr,
                         input logic [7:0] e_rgb, input logic [1:0] e_id,
                         input logic e_col);
    chk({name, ".dr"}, 32'(drawingRequest), 32'(e_dr));
    chk({name, ".rgb"}, 32'(RGBout), 32'(e_rgb));
    chk({name, ".id"}, 32'(layer_id), 32'(e_id));
    chk({name, ".col"}, 32'(collision), 32'(e_col));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_valid = 1'b0;
    startOfFrame = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  int cnt_m;
  logic ph_m;

  initial begin
    vecs[0] = '{4'b0110, 1'b1, 8'hE0, 2'd1, 1'b1};
    vecs[1] = '{4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[2] = '{4'b1000, 1'b1, 8'hFF, 2'd3, 1'b0};
    vecs[3] = '{4'b1100, 1'b1, 8'h1C, 2'd2, 1'b1};
    vecs[4] = '{4'b0001, 1'b1, 8'h03, 2'd0, 1'b0};
    vecs[5] = '{4'b1111, 1'b1, 8'h03, 2'd0, 1'b1};

    RGB_in       = {8'hFF, 8'h1C, 8'hE0, 8'h03};
    DR_in        = 4'b1111;
    cfg_priority = 8'h00;
    cfg_enable   = 4'b0000;
    cfg_blink    = 4'b0000;
    cfg_valid    = 1'b0;
    startOfFrame = 1'b0;
    reset        = 1'b1;

    // reset values
    tick();
    tick();
    chk_pix("rst", 1'b0, 8'h00, 2'd0, 1'b0);
    chk("rst.ready", 32'(cfg_ready), 32'd0);
    chk("rst.phase", 32'(blink_phase), 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_rise", 32'(cfg_ready), 32'd1);

    // identity table
    for (int k = 0; k < 6; k++) begin
      DR_in = vecs[k].dr;
      tick();
      chk_pix($sformatf("vec%0d", k), vecs[k].e_dr, vecs[k].e_rgb,
              vecs[k].e_id, vecs[k].e_col);
    end

    // buffered commit via PENDING
    DR_in        = 4'b0110;
    cfg_priority = 8'h1E;
    cfg_enable   = 4'b1111;
    cfg_blink    = 4'b0000;
    cfg_valid    = 1'b1;
    tick();
    chk("pend.ready", 32'(cfg_ready), 32'd0);
    chk_pix("pend.p0", 1'b1, 8'hE0, 2'd1, 1'b1);
    cfg_valid    = 1'b0;
    tick();
    chk_pix("pend.p1", 1'b1, 8'hE0, 2'd1, 1'b1);
    cfg_priority = 8'hE4;
    cfg_valid    = 1'b1;
    tick();
    chk("pend.ign_ready", 32'(cfg_ready), 32'd0);
    cfg_valid    = 1'b0;
    startOfFrame = 1'b1;
    tick();
    chk_pix("pend.sof_pix", 1'b1, 8'hE0, 2'd1, 1'b1);
    chk("pend.ready_back", 32'(cfg_ready), 32'd1);
    startOfFrame = 1'b0;
    tick();
    chk_pix("pend.new", 1'b1, 8'h1C, 2'd2, 1'b1);
    DR_in = 4'b1010;
    tick();
    chk_pix("pend.new2", 1'b1, 8'hFF, 2'd3, 1'b1);

    // same-cycle commit from IDLE
    DR_in        = 4'b0011;
    cfg_priority = 8'hE4;
    cfg_enable   = 4'b1101;
    cfg_valid    = 1'b1;
    startOfFrame = 1'b1;
    tick();
    chk_pix("direct.old", 1'b1, 8'hE0, 2'd1, 1'b1);
    chk("direct.ready0", 32'(cfg_ready), 32'd1);
    cfg_valid    = 1'b0;
    startOfFrame = 1'b0;
    tick();
    chk_pix("direct.new", 1'b1, 8'h03, 2'd0, 1'b0);
    chk("direct.ready1", 32'(cfg_ready), 32'd1);

    // duplicate slots all pointing at layer 0
    cfg_priority = 8'h00;
    cfg_enable   = 4'b1111;
    cfg_valid    = 1'b1;
    startOfFrame = 1'b1;
    tick();
    cfg_valid    = 1'b0;
    startOfFrame = 1'b0;
    DR_in        = 4'b0010;
    tick();
    chk_pix("dup.l1", 1'b0, 8'h00, 2'd0, 1'b0);
    DR_in = 4'b0011;
    tick();
    chk_pix("dup.l01", 1'b1, 8'h03, 2'd0, 1'b1);

    // reset while PENDING discards shadow
    do_reset();
    cfg_priority = 8'h1E;
    cfg_valid    = 1'b1;
    tick();
    chk("rp.pending", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    DR_in     = 4'b0110;
    reset     = 1'b1;
    tick();
    chk_pix("rp.rst", 1'b0, 8'h00, 2'd0, 1'b0);
    chk("rp.rst_ready", 32'(cfg_ready), 32'd0);
    reset = 1'b0;
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    chk_pix("rp.ident", 1'b1, 8'hE0, 2'd1, 1'b1);

    // blink with BLINK_FRAMES=2 on layer 1
    do_reset();
    cnt_m = 0;
    ph_m  = 1'b0;
    cfg_priority = 8'hE4;
    cfg_enable   = 4'b1111;
    cfg_blink    = 4'b0010;
    cfg_valid    = 1'b1;
    startOfFrame = 1'b1;
    DR_in        = 4'b0010;
    tick();
    cnt_m = 1;
    cfg_valid    = 1'b0;
    startOfFrame = 1'b0;
    for (int f = 0; f < 8; f++) begin
      tick();
      chk($sformatf("blink.f%0d.dr", f), 32'(drawingRequest), 32'(!ph_m));
      chk($sformatf("blink.f%0d.ph", f), 32'(blink_phase), 32'(ph_m));
      tick();
      chk($sformatf("blink.f%0d.mid", f), 32'(blink_phase), 32'(ph_m));
      startOfFrame = 1'b1;
      tick();
      chk($sformatf("blink.f%0d.sofpix", f), 32'(drawingRequest),
          32'(!ph_m));
      if (cnt_m == 1) begin
        cnt_m = 0;
        ph_m  = ~ph_m;
      end else begin
        cnt_m = cnt_m + 1;
      end
      chk($sformatf("blink.f%0d.phnew", f), 32'(blink_phase), 32'(ph_m));
      startOfFrame = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
